riscv_memory: RTL and testbench

RISCV_MEMORY -- requirements
Module: riscv_memory

---
 rtl/riscv_memory.sv | 157 +++++++++++++++
 tb/tb_riscv_memory.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_memory.sv
// M stage of the RISC-V pipeline: drives the data-memory port, stalls on slow
// memory, aborts hung accesses and registers the W-stage fields.
`ifndef XLEN
`define XLEN 32
`endif

module riscv_memory #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_valid_m,
    input  logic [`XLEN-1:0]  i_alu_result_m,
    input  logic [`XLEN-1:0]  i_write_data_m,
    input  logic [`XLEN-1:0]  i_pc_plus_4m,
    input  logic [`XLEN-1:0]  i_ext_imm_m,
    input  logic [4:0]        i_rd_m,
    input  logic              i_reg_write_m,
    input  logic [1:0]        i_result_src_m,
    input  logic              i_mem_write_m,
    input  logic [2:0]        i_funct3_m,
    output logic              o_dmem_req,
    output logic              o_dmem_we,
    output logic [`XLEN-1:0]  o_dmem_addr,
    output logic [`XLEN-1:0]  o_dmem_wdata,
    output logic [3:0]        o_dmem_wstrb,
    input  logic              i_dmem_ack,
    input  logic [`XLEN-1:0]  i_dmem_rdata,
    output logic              o_stall_m,
    output logic              o_misalign_w,
    output logic              o_timeout_w,
    output logic              o_valid_w,
    output logic [`XLEN-1:0]  o_alu_result_w,
    output logic [`XLEN-1:0]  o_read_data_w,
    output logic [`XLEN-1:0]  o_pc_plus_4w,
    output logic [`XLEN-1:0]  o_ext_imm_w,
    output logic [4:0]        o_rd_w,
    output logic              o_reg_write_w,
    output logic [1:0]        o_result_src_w
);

    typedef enum logic {S_IDLE, S_WAIT} state_e;

    state_e           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             is_load, is_store, is_mem, legal, aligned;
    logic             pending, misalign, abort, load_ok;
    logic [`XLEN-1:0] lane, load_data;

    always_comb begin
        is_load  = (i_result_src_m == 2'b01);
        is_store = i_mem_write_m;
        is_mem   = i_valid_m & (is_load | is_store);
        if (is_store) legal = (i_funct3_m inside {3'b000, 3'b001, 3'b010});
        else          legal = (i_funct3_m inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        case (i_funct3_m[1:0])
            2'b01:   aligned = ~i_alu_result_m[0];
            2'b10:   aligned = (i_alu_result_m[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

    assign pending  = is_mem & legal & aligned;
    assign misalign = is_mem & ~(legal & aligned);
    // The abort cycle itself no longer requests, so a late ack cannot race the abort.
    assign abort      = i_rstn & (state_q == S_WAIT) & (cnt_q == 8'(MEM_TIMEOUT));
    assign o_dmem_req = i_rstn & (((state_q == S_IDLE) & pending) | ((state_q == S_WAIT) & ~abort));
    assign o_stall_m  = o_dmem_req & ~i_dmem_ack & ~abort;
    assign load_ok    = pending & is_load & ~is_store & o_dmem_req & i_dmem_ack;

    assign o_dmem_we   = i_mem_write_m;
    assign o_dmem_addr = {i_alu_result_m[`XLEN-1:2], 2'b00};

    always_comb begin
        o_dmem_wdata = i_write_data_m;
        o_dmem_wstrb = 4'b0000;
        case (i_funct3_m[1:0])
            2'b00:   o_dmem_wdata = {4{i_write_data_m[7:0]}};
            2'b01:   o_dmem_wdata = {2{i_write_data_m[15:0]}};
            default: o_dmem_wdata = i_write_data_m;
        endcase
        if (is_store) begin
            case (i_funct3_m[1:0])
                2'b00:   o_dmem_wstrb = 4'b0001 << i_alu_result_m[1:0];
                2'b01:   o_dmem_wstrb = 4'b0011 << i_alu_result_m[1:0];
                default: o_dmem_wstrb = 4'b1111;
            endcase
        end
    end

    always_comb begin
        lane = i_dmem_rdata >> {i_alu_result_m[1:0], 3'b000};
        case (i_funct3_m)
            3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
            3'b100:  load_data = {24'd0, lane[7:0]};
            3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
            3'b101:  load_data = {16'd0, lane[15:0]};
            default: load_data = lane;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (pending && !i_dmem_ack) begin
                    state_d = S_WAIT;
                    cnt_d   = 8'd0;
                end
            end
            S_WAIT: begin
                if (i_dmem_ack || abort) state_d = S_IDLE;
                else                     cnt_d   = cnt_q + 8'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A stalled cycle retires nothing: W gets an all-zero bubble.
    always_ff @(posedge i_clk) begin
        if (!i_rstn || o_stall_m) begin
            o_valid_w      <= 1'b0;
            o_alu_result_w <= '0;
            o_read_data_w  <= '0;
            o_pc_plus_4w   <= '0;
            o_ext_imm_w    <= '0;
            o_rd_w         <= 5'd0;
            o_reg_write_w  <= 1'b0;
            o_result_src_w <= 2'b00;
            o_misalign_w   <= 1'b0;
            o_timeout_w    <= 1'b0;
        end else begin
            o_valid_w      <= i_valid_m;
            o_alu_result_w <= i_alu_result_m;
            o_read_data_w  <= load_ok ? load_data : '0;
            o_pc_plus_4w   <= i_pc_plus_4m;
            o_ext_imm_w    <= i_ext_imm_m;
            o_rd_w         <= i_rd_m;
            o_reg_write_w  <= i_valid_m & i_reg_write_m & ~misalign & ~abort;
            o_result_src_w <= i_result_src_m;
            o_misalign_w   <= misalign;
            o_timeout_w    <= abort;
        end
    end

endmodule

// File: tb/tb_riscv_memory.sv
// Self-checking bench for riscv_memory: directed memory cases, reset mid-wait,
// timeout abort and a random mix, with W results checked from a scoreboard.
`ifndef XLEN
`define XLEN 32
`endif

module tb_riscv_memory;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        valid_m, reg_write_m, mem_write_m;
    logic [31:0] alu_m, wdata_m, pc4_m, imm_m;
    logic [4:0]  rd_m;
    logic [1:0]  src_m;
    logic [2:0]  f3_m;
    logic        dmem_req, dmem_we, dmem_ack, stall_m;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
    logic        misalign_w, timeout_w, valid_w, reg_write_w;
    logic [31:0] alu_w, rdata_w, pc4_w, imm_w;
    logic [4:0]  rd_w;
    logic [1:0]  src_w;

    always #5 clk = ~clk;

    riscv_memory #(.MEM_TIMEOUT(TMO)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_valid_m(valid_m), .i_alu_result_m(alu_m),
        .i_write_data_m(wdata_m), .i_pc_plus_4m(pc4_m), .i_ext_imm_m(imm_m), .i_rd_m(rd_m),
        .i_reg_write_m(reg_write_m), .i_result_src_m(src_m), .i_mem_write_m(mem_write_m),
        .i_funct3_m(f3_m), .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr),
        .o_dmem_wdata(dmem_wdata), .o_dmem_wstrb(dmem_wstrb), .i_dmem_ack(dmem_ack),
        .i_dmem_rdata(dmem_rdata), .o_stall_m(stall_m), .o_misalign_w(misalign_w),
        .o_timeout_w(timeout_w), .o_valid_w(valid_w), .o_alu_result_w(alu_w),
        .o_read_data_w(rdata_w), .o_pc_plus_4w(pc4_w), .o_ext_imm_w(imm_w), .o_rd_w(rd_w),
        .o_reg_write_w(reg_write_w), .o_result_src_w(src_w)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [40:0] exp_q[$];

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic bit model_ok(input bit st, input logic [2:0] f3, input logic [31:0] a);
        bit legal_f;
        if (st) legal_f = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        else    legal_f = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        if (!legal_f) return 1'b0;
        if (f3[1:0] == 2'd1) return a[0] == 1'b0;
        if (f3[1:0] == 2'd2) return a[1:0] == 2'b00;
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*a[1:0] +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'd0:    return {{24{b[7]}}, b};
            3'd4:    return {24'd0, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd5:    return {16'd0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] model_strb(input bit st, input logic [2:0] f3, input logic [1:0] a);
        if (!st) return 4'b0000;
        case (f3)
            3'd0:    return 4'b0001 << a;
            3'd1:    return 4'b0011 << a;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'd0:    return {d[7:0], d[7:0], d[7:0], d[7:0]};
            3'd1:    return {d[15:0], d[15:0]};
            default: return d;
        endcase
    endfunction

    task automatic drive_idle();
        valid_m = 1'b0; reg_write_m = 1'b0; mem_write_m = 1'b0; src_m = 2'b00; f3_m = 3'd0;
        alu_m = '0; wdata_m = '0; pc4_m = '0; imm_m = '0; rd_m = '0;
        dmem_ack = 1'b0; dmem_rdata = '0;
    endtask

    task automatic check_w_zero(input string tag);
        check(tag, {valid_w, reg_write_w, misalign_w, timeout_w, rd_w, src_w, alu_w, rdata_w},
              {1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 32'd0, 32'd0});
        check({tag, "_pi"}, {pc4_w, imm_w}, 64'd0);
    endtask

    // Called at a negedge; returns at the negedge after the instruction reaches W.
    // delay < 0 means memory never acknowledges.
    task automatic do_access(input string tag, input bit valid, input bit ld, input bit st,
                             input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input int delay, input logic [31:0] rdata);
        bit          is_mem, ok, misal, tmo, done, rw;
        int          exp_req, exp_stall, n_req, n_stall, n_bub, k;
        logic [31:0] exp_rd, pc4, imm;
        logic [4:0]  rd;
        logic [1:0]  src;
        logic [40:0] exp, got;
        is_mem = valid & (ld | st);
        ok     = model_ok(st, f3, addr);
        misal  = is_mem & !ok;
        tmo    = is_mem & ok & (delay < 0);
        rw     = !st;
        src    = ld ? 2'b01 : 2'b10;
        exp_req   = (!is_mem || !ok) ? 0 : ((delay < 0) ? TMO + 1 : delay + 1);
        exp_stall = (exp_req == 0) ? 0 : ((delay < 0) ? TMO + 1 : delay);
        exp_rd = (is_mem && ok && ld && !st && delay >= 0) ? model_load(f3, addr, rdata) : 32'd0;
        rd  = 5'($urandom_range(1, 31));
        pc4 = $urandom;
        imm = $urandom;
        exp = {valid, valid & rw & !misal & !tmo, misal, tmo, rd, exp_rd};
        exp_q.push_back(exp);

        valid_m = valid; alu_m = addr; wdata_m = wd; pc4_m = pc4; imm_m = imm; rd_m = rd;
        reg_write_m = rw; src_m = src; mem_write_m = st; f3_m = f3;
        dmem_rdata = rdata; dmem_ack = (delay == 0);
        done = 1'b0; n_req = 0; n_stall = 0; n_bub = 0; k = 0;
        while (!done && k < 40) begin
            #1;
            if (dmem_req) begin
                n_req++;
                check({tag, "_bus"}, {dmem_we, dmem_wstrb, dmem_wdata, dmem_addr},
                      {st, model_strb(st, f3, addr[1:0]),
                       st ? model_wdata(f3, wd) : wd, addr[31:2], 2'b00});
            end
            if (stall_m) n_stall++;
            else         done = 1'b1;
            @(posedge clk);
            @(negedge clk);
            if (!done && !valid_w && !reg_write_w) n_bub++;
            k++;
            dmem_ack = (k == delay);
        end
        dmem_ack = 1'b0;
        if (!done) check({tag, "_stall_bound"}, 1'b0, 1'b1);
        check({tag, "_reqcyc"}, n_req, exp_req);
        check({tag, "_stallcyc"}, n_stall, exp_stall);
        check({tag, "_bubbles"}, n_bub, exp_stall);
        got = {valid_w, reg_write_w, misalign_w, timeout_w, rd_w, rdata_w};
        check({tag, "_w"}, got, exp_q.pop_front());
        check({tag, "_wfld"}, {alu_w, pc4_w, imm_w, src_w}, {addr, pc4, imm, src});
    endtask

    int lf[5] = '{0, 1, 2, 4, 5};

    initial begin
        rstn = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_stall", {dmem_req, stall_m}, 2'b00);
        check_w_zero("rst_w");
        @(negedge clk);
        rstn = 1'b1;

        do_access("lw_zero_wait", 1, 1, 0, 3'd2, 32'h100, 0, 0, 32'hDEADBEEF);
        check("lw_data", {valid_w, rdata_w}, {1'b1, 32'hDEADBEEF});
        do_access("lb", 1, 1, 0, 3'd0, 32'h103, 0, 0, 32'h80000000);
        check("lb_data", rdata_w, 32'hFFFFFF80);
        do_access("lbu", 1, 1, 0, 3'd4, 32'h103, 0, 1, 32'h80000000);
        check("lbu_data", rdata_w, 32'h00000080);
        do_access("lh", 1, 1, 0, 3'd1, 32'h102, 0, 2, 32'h80000000);
        check("lh_data", rdata_w, 32'hFFFF8000);
        do_access("sh_wait3", 1, 0, 1, 3'd1, 32'h202, 32'h0000ABCD, 3, 0);
        check("sh_bus", {dmem_wstrb, dmem_wdata}, {4'b1100, 32'hABCDABCD});
        do_access("lw_misal", 1, 1, 0, 3'd2, 32'h101, 0, 0, 32'h12345678);
        check("misal_flag", {misalign_w, reg_write_w}, 2'b10);
        do_access("alu_after", 1, 0, 0, 3'd0, 32'h55, 0, 0, 0);
        do_access("ld_illegal", 1, 1, 0, 3'd3, 32'h40, 0, 0, 32'h1);
        do_access("st_illegal", 1, 0, 1, 3'd4, 32'h40, 32'h9, 0, 0);
        do_access("timeout", 1, 1, 0, 3'd2, 32'h300, 0, -1, 32'hCAFEF00D);
        check("tmo_flag", {timeout_w, reg_write_w, rdata_w}, {1'b1, 1'b0, 32'd0});
        do_access("bubble_in", 0, 1, 0, 3'd2, 32'h100, 0, 0, 32'h1);

        // Reset asserted while a store is waiting for its acknowledge.
        valid_m = 1'b1; alu_m = 32'h202; wdata_m = 32'hABCD; mem_write_m = 1'b1;
        reg_write_m = 1'b0; src_m = 2'b10; f3_m = 3'd1; rd_m = 5'd3; dmem_ack = 1'b0;
        #1 check("rw_req0", dmem_req, 1'b1);
        @(posedge clk); @(negedge clk);
        #1 check("rw_req1", dmem_req, 1'b1);
        rstn = 1'b0;
        #1 check("rw_rst_req", {dmem_req, stall_m}, 2'b00);
        @(posedge clk); @(negedge clk);
        check_w_zero("rw_rst_w");
        rstn = 1'b1;
        drive_idle();
        dmem_ack = 1'b1;
        #1 check("stale_ack_req", dmem_req, 1'b0);
        @(posedge clk); @(negedge clk);
        dmem_ack = 1'b0;
        check("stale_ack_w", {valid_w, reg_write_w, rdata_w}, 34'd0);
        do_access("post_rst_lw", 1, 1, 0, 3'd2, 32'h104, 0, 0, 32'h0BADF00D);

        for (int i = 0; i < 24; i++) begin
            int          kind, dly;
            logic [2:0]  f3;
            logic [31:0] a;
            kind = $urandom_range(0, 3);
            dly  = $urandom_range(0, 3);
            a    = $urandom;
            case (kind)
                0: begin
                    f3 = 3'(lf[$urandom_range(0, 4)]);
                    if (f3[1:0] == 2'd1) a[0] = 1'b0;
                    if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
                    do_access("rnd_ld", 1, 1, 0, f3, a, 0, dly, $urandom);
                end
                1: begin
                    f3 = 3'($urandom_range(0, 2));
                    if (f3 == 3'd1) a[0] = 1'b0;
                    if (f3 == 3'd2) a[1:0] = 2'b00;
                    do_access("rnd_st", 1, 0, 1, f3, a, $urandom, dly, 0);
                end
                2: do_access("rnd_alu", 1, 0, 0, 3'($urandom_range(0, 7)), a, 0, 0, 0);
                default: do_access("rnd_mix", 1, 1, 0, 3'($urandom_range(0, 7)), a, 0, dly, $urandom);
            endcase
        end

        drive_idle();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
